ndp_result_drain: RTL and testbench

- Transmit-side counterpart of the NDP core's 32-bit data ingest path.
- On calc_done_flag, snapshots the wide out_c result vector, then streams it to the host 32 bits per transfer over a valid/ready handshake.
- Sits between NDP_core's result outputs and the host/DMA read port. The core may be reset and refilled while the drain empties its shadow copy.

---
 rtl/ndp_pkg.sv | 23 ++
 rtl/ndp_word_select.sv | 33 +++
 rtl/ndp_result_drain.sv | 138 +++++++++++++
 tb/tb_ndp_result_drain.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ndp_pkg.sv
// Shared types and size helpers for the NDP result drain path.
package ndp_pkg;

  localparam int DEFAULT_OUT_BITS = 32;

  function automatic int total_bits(input int width, input int arr_width,
                                    input int arr_height, input int sys_width,
                                    input int sys_height);
    return arr_width * sys_width * arr_height * sys_height * width;
  endfunction

  function automatic int num_words(input int tot_bits, input int out_bits);
    return tot_bits / out_bits;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_DONE     = 2'd2,
    ST_WAIT_LOW = 2'd3
  } drain_state_e;

endpackage

// File: rtl/ndp_word_select.sv
// Shadow copy of the result vector; shifts right one host word per transfer so
// the current word is always in the low bits.
module ndp_word_select #(
  parameter int TOTAL_BITS = 16384,
  parameter int OUT_BITS   = 32
) (
  input  logic                  clk,
  input  logic                  capture,
  input  logic                  shift,
  input  logic [TOTAL_BITS-1:0] out_c,
  output logic [OUT_BITS-1:0]   word_lo
);

  logic [TOTAL_BITS-1:0] shadow_q;
  logic [TOTAL_BITS-1:0] shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (capture) begin
      shadow_d = out_c;
    end else if (shift) begin
      shadow_d = shadow_q >> OUT_BITS;
    end
  end

  // Contents are meaningless until the first capture, so no reset is needed.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign word_lo = shadow_q[OUT_BITS-1:0];

endmodule

// File: rtl/ndp_result_drain.sv
// Drains a snapshot of the NDP core's out_c vector to the host, one OUT_BITS word
// per valid/ready transfer. Define NDP_DRAIN_CHECKSUM_EN to append an XOR checksum word.
module ndp_result_drain
  import ndp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ARR_WIDTH  = 4,
  parameter int ARR_HEIGHT = 4,
  parameter int SYS_WIDTH  = 64,
  parameter int SYS_HEIGHT = 1,
  parameter int OUT_BITS   = DEFAULT_OUT_BITS,
  localparam int TOTAL_BITS = total_bits(WIDTH, ARR_WIDTH, ARR_HEIGHT, SYS_WIDTH, SYS_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  calc_done_flag,
  input  logic [TOTAL_BITS-1:0] out_c,
  input  logic                  data_out_ready,
  output logic                  data_out_flag,
  output logic [OUT_BITS-1:0]   data_out,
  output logic                  drain_busy,
  output logic                  drain_done_flag
);

  localparam int NUM_WORDS = num_words(TOTAL_BITS, OUT_BITS);
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);
`ifdef NDP_DRAIN_CHECKSUM_EN
  localparam int LAST_IDX  = NUM_WORDS;
`else
  localparam int LAST_IDX  = NUM_WORDS - 1;
`endif

  // Handshake: a word moves on a rising edge where data_out_flag & data_out_ready;
  // while flag is high and ready low, data_out holds and flag stays up.

  drain_state_e       state_q, state_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               capture;
  logic               xfer;
  logic               last_xfer;
  logic [OUT_BITS-1:0] word_lo;

  assign capture   = (state_q == ST_IDLE) && calc_done_flag;
  assign xfer      = (state_q == ST_SEND) && data_out_ready;
  assign last_xfer = xfer && (word_cnt_q == CNT_W'(LAST_IDX));

  ndp_word_select #(
    .TOTAL_BITS(TOTAL_BITS),
    .OUT_BITS  (OUT_BITS)
  ) u_word_select (
    .clk    (clk),
    .capture(capture),
    .shift  (xfer),
    .out_c  (out_c),
    .word_lo(word_lo)
  );

`ifdef NDP_DRAIN_CHECKSUM_EN
  logic [OUT_BITS-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (capture) begin
      csum_d = '0;
    end else if (xfer && (word_cnt_q < CNT_W'(NUM_WORDS))) begin
      csum_d = csum_q ^ word_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Next state; the counter parks on the last index instead of wrapping.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (calc_done_flag) begin
          state_d    = ST_SEND;
          word_cnt_d = '0;
        end
      end
      ST_SEND: begin
        if (last_xfer) begin
          state_d = ST_DONE;
        end else if (xfer) begin
          word_cnt_d = word_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!calc_done_flag) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    data_out_flag   = (state_q == ST_SEND);
    drain_busy      = (state_q == ST_SEND);
    drain_done_flag = (state_q == ST_DONE);
    data_out        = '0;
    if (state_q == ST_SEND) begin
      data_out = word_lo;
`ifdef NDP_DRAIN_CHECKSUM_EN
      if (word_cnt_q == CNT_W'(NUM_WORDS)) begin
        data_out = csum_q;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ndp_result_drain.sv
// Directed bench for ndp_result_drain: streaming, backpressure, capture isolation,
// rearm, mid-stream reset and the data pattern used for the checksum word.
module tb_ndp_result_drain;

  localparam int TOTAL     = 16384;
  localparam int NWORDS    = 512;
  localparam int STREAM_MAX = 4000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             calc_done_flag = 1'b0;
  logic [TOTAL-1:0] out_c = '0;
  logic             data_out_ready = 1'b0;
  logic             data_out_flag;
  logic [31:0]      data_out;
  logic             drain_busy;
  logic             drain_done_flag;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];

  ndp_result_drain dut (
    .clk            (clk),
    .reset          (reset),
    .calc_done_flag (calc_done_flag),
    .out_c          (out_c),
    .data_out_ready (data_out_ready),
    .data_out_flag  (data_out_flag),
    .data_out       (data_out),
    .drain_busy     (drain_busy),
    .drain_done_flag(drain_done_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [TOTAL-1:0] seq_pattern();
    logic [TOTAL-1:0] v;
    v = '0;
    for (int k = 0; k < NWORDS; k++) begin
      v[k*32 +: 32] = k;
    end
    return v;
  endfunction

  task automatic fill_seq();
    exp_q.delete();
    for (int k = 0; k < NWORDS; k++) exp_q.push_back(k);
`ifdef NDP_DRAIN_CHECKSUM_EN
    exp_q.push_back(32'h0);  // XOR of 0..511
`endif
  endtask

  // Entered #1 after the capture edge; drains exp_q, then checks the done pulse.
  task automatic stream_check(input int mode);
    logic [31:0] hold_val;
    bit holding;
    int cyc;
    holding = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < STREAM_MAX) begin
      data_out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      @(negedge clk);
      chk("flag_high", data_out_flag, 1'b1);
      chk("busy_high", drain_busy, 1'b1);
      if (holding) chk("hold_stable", data_out, hold_val);
      if (data_out_ready) begin
        chk("data_word", data_out, exp_q.pop_front());
        holding = 1'b0;
      end else begin
        hold_val = data_out;
        holding = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      chk("stream_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
    data_out_ready = 1'b0;
    @(negedge clk);
    chk("flag_low_after", data_out_flag, 1'b0);
    chk("busy_low_after", drain_busy, 1'b0);
    chk("done_pulse", drain_done_flag, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_one_cycle", drain_done_flag, 1'b0);
  endtask

  initial begin
    logic [TOTAL-1:0] ones;
    ones = '1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_flag", data_out_flag, 1'b0);
    chk("rst_busy", drain_busy, 1'b0);
    chk("rst_done", drain_done_flag, 1'b0);
    chk("rst_data", data_out, 32'h0);

    // Basic stream with ready held high
    repeat (6) @(posedge clk);
    #1;
    out_c = seq_pattern();
    calc_done_flag = 1'b1;
    @(negedge clk);
    chk("pre_capture_flag", data_out_flag, 1'b0);
    @(posedge clk); #1;
    calc_done_flag = 1'b0;
    fill_seq();
    stream_check(0);

    // Backpressure + capture isolation; calc_done_flag stays high through DONE
    @(posedge clk); #1;
    calc_done_flag = 1'b1;
    @(posedge clk); #1;
    out_c = ones;
    fill_seq();
    stream_check(1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("no_rearm_flag", data_out_flag, 1'b0);
      chk("no_rearm_busy", drain_busy, 1'b0);
    end

    // Rearm: drop for one cycle, then raise again
    @(posedge clk); #1;
    calc_done_flag = 1'b0;
    out_c = seq_pattern();
    @(posedge clk); #1;
    calc_done_flag = 1'b1;
    @(negedge clk);
    chk("rearm_pre_flag", data_out_flag, 1'b0);
    @(posedge clk); #1;
    calc_done_flag = 1'b0;
    fill_seq();
    stream_check(0);

    // Reset on the edge after word 100 transfers
    @(posedge clk); #1;
    calc_done_flag = 1'b1;
    @(posedge clk); #1;
    calc_done_flag = 1'b0;
    data_out_ready = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      chk("pre_reset_data", data_out, i);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    data_out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_flag", data_out_flag, 1'b0);
    chk("abort_busy", drain_busy, 1'b0);
    chk("abort_data", data_out, 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_quiet", data_out_flag, 1'b0);
    end
    @(posedge clk); #1;
    calc_done_flag = 1'b1;
    @(posedge clk); #1;
    calc_done_flag = 1'b0;
    fill_seq();
    stream_check(0);

    // Sparse pattern: only word 0 nonzero
    @(posedge clk); #1;
    out_c = '0;
    out_c[31:0] = 32'h1234_5678;
    calc_done_flag = 1'b1;
    @(posedge clk); #1;
    calc_done_flag = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h1234_5678);
    for (int k = 1; k < NWORDS; k++) exp_q.push_back(32'h0);
`ifdef NDP_DRAIN_CHECKSUM_EN
    exp_q.push_back(32'h1234_5678);
`endif
    stream_check(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
